// File: rtl/lives_manager_if.sv
// Purpose: event/status bundle between game logic, lives_manager and the LED controller.
// Ports: start/hit/extra_life event pulses in; lives/invulnerable/game_over/life_lost status out.
// master = event producer / status consumer, slave = lives_manager.
interface lives_manager_if;
  logic       start;
  logic       hit;
  logic       extra_life;
  logic [2:0] lives;
  logic       invulnerable;
  logic       game_over;
  logic       life_lost;

  modport master (
    output start, hit, extra_life,
    input  lives, invulnerable, game_over, life_lost
  );

  modport slave (
    input  start, hit, extra_life,
    output lives, invulnerable, game_over, life_lost
  );
endinterface

// File: rtl/lives_manager.sv
// Purpose: player-lives bookkeeping. Turns hit/bonus/start pulses into a saturating
//   lives count, a post-hit invulnerability window and a game-over flag.
// Ports: clk, reset (async, active-high), bus (lives_manager_if.slave): start, hit,
//   extra_life in; lives[2:0], invulnerable, game_over, life_lost out.
// Latency: all outputs registered; an event sampled at edge N shows after edge N.
// Backpressure: none; every pulse is consumed or deliberately ignored on its edge.
module lives_manager #(
  parameter int INIT_LIVES    = 3,
  parameter int MAX_LIVES     = 7,
  parameter int INVULN_CYCLES = 50000000
) (
  input logic              clk,
  input logic              reset,
  lives_manager_if.slave   bus
);

  localparam int             TW         = $clog2(INVULN_CYCLES) + 1;
  localparam logic [TW-1:0]  TIMER_LOAD = TW'(INVULN_CYCLES - 1);
  localparam logic [2:0]     INIT_L     = 3'(INIT_LIVES);
  localparam logic [2:0]     MAX_L      = 3'(MAX_LIVES);

  typedef enum logic [1:0] {IDLE, PLAY, INVULN, OVER} state_t;

  state_t        state;
  logic [TW-1:0] timer;

  // Bonus increment that sticks at the ceiling; ">=" keeps it safe when MAX_L is 7
  // and lives+1 would otherwise wrap to 0.
  function automatic logic [2:0] inc_sat(input logic [2:0] v);
    return (v >= MAX_L) ? MAX_L : v + 3'd1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      timer            <= '0;
      bus.lives        <= INIT_L;
      bus.invulnerable <= 1'b0;
      bus.game_over    <= 1'b0;
      bus.life_lost    <= 1'b0;
    end else begin
      bus.life_lost <= 1'b0;
      if (bus.start) begin
        // start wins over everything, including a concurrent hit/bonus.
        state            <= PLAY;
        timer            <= '0;
        bus.lives        <= INIT_L;
        bus.invulnerable <= 1'b0;
        bus.game_over    <= 1'b0;
      end else begin
        case (state)
          IDLE: ;
          PLAY: begin
            if (bus.hit) begin
              bus.life_lost <= 1'b1;
              if (bus.extra_life) begin
                // Hit and bonus cancel: count unchanged, but the hit still
                // opens the immunity window.
                state            <= INVULN;
                timer            <= TIMER_LOAD;
                bus.invulnerable <= 1'b1;
              end else if (bus.lives == 3'd1) begin
                state         <= OVER;
                bus.lives     <= 3'd0;
                bus.game_over <= 1'b1;
              end else begin
                state            <= INVULN;
                timer            <= TIMER_LOAD;
                bus.lives        <= bus.lives - 3'd1;
                bus.invulnerable <= 1'b1;
              end
            end else if (bus.extra_life) begin
              bus.lives <= inc_sat(bus.lives);
            end
          end
          INVULN: begin
            // Hits are swallowed here; bonuses still count.
            if (bus.extra_life) begin
              bus.lives <= inc_sat(bus.lives);
            end
            // Loaded with N-1 and left on the edge that sees 0, giving N cycles.
            if (timer == '0) begin
              state            <= PLAY;
              bus.invulnerable <= 1'b0;
            end else begin
              timer <= timer - 1'b1;
            end
          end
          OVER: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lives_manager.sv
// Bench for lives_manager: a table of hand-derived vectors on an INVULN_CYCLES=4
// instance, an async-reset sequence, then random pulses on both a 4-cycle and a
// 1-cycle-window instance compared against an event-level model of the game rules.
module tb_lives_manager;

  localparam int INIT = 3;
  localparam int MAXL = 7;

  logic clk;
  logic reset;

  lives_manager_if bus4 ();
  lives_manager_if bus1 ();

  assign bus1.start      = bus4.start;
  assign bus1.hit        = bus4.hit;
  assign bus1.extra_life = bus4.extra_life;

  lives_manager #(.INIT_LIVES(INIT), .MAX_LIVES(MAXL), .INVULN_CYCLES(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4.slave)
  );

  lives_manager #(.INIT_LIVES(INIT), .MAX_LIVES(MAXL), .INVULN_CYCLES(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- reference model (game rules, not the RTL states) ----------
  typedef struct {
    bit started;   // a start has been seen since reset
    int lives;
    int inv_left;  // immunity cycles still to run
    bit ll;        // life lost on the last edge
  } mstate_t;

  mstate_t m4, m1;

  function automatic mstate_t mreset();
    mstate_t r;
    r.started = 0; r.lives = INIT; r.inv_left = 0; r.ll = 0;
    return r;
  endfunction

  function automatic mstate_t mstep(input mstate_t m, input bit s, input bit h,
                                    input bit e, input int window);
    mstate_t n = m;
    n.ll = 0;
    if (s) begin
      n.started = 1; n.lives = INIT; n.inv_left = 0;
    end else if (!m.started || m.lives == 0) begin
      // waiting for start, or game over: nothing counts
    end else if (m.inv_left > 0) begin
      n.inv_left = m.inv_left - 1;
      if (e) n.lives = (m.lives + 1 > MAXL) ? MAXL : m.lives + 1;
    end else if (h) begin
      n.ll = 1;
      if (!e) n.lives = m.lives - 1;
      if (n.lives > 0) n.inv_left = window;
    end else if (e) begin
      n.lives = (m.lives + 1 > MAXL) ? MAXL : m.lives + 1;
    end
    return n;
  endfunction

  // ---------------- stimulus / checking helpers --------------------------------
  task automatic step(input bit s, input bit h, input bit e);
    @(negedge clk);
    bus4.start = s; bus4.hit = h; bus4.extra_life = e;
    m4 = mstep(m4, s, h, e, 4);
    m1 = mstep(m1, s, h, e, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic check4(input string name, input int l, input bit inv, input bit go, input bit ll);
    checks++;
    if (int'(bus4.lives) != l || bus4.invulnerable != inv || bus4.game_over != go ||
        bus4.life_lost != ll) begin
      errors++;
      $display("FAIL %s: got lives=%0d inv=%0b go=%0b ll=%0b, want lives=%0d inv=%0b go=%0b ll=%0b",
               name, bus4.lives, bus4.invulnerable, bus4.game_over, bus4.life_lost,
               l, inv, go, ll);
    end
  endtask

  task automatic check_model(input int cyc);
    checks++;
    if (int'(bus4.lives) != m4.lives || bus4.invulnerable != (m4.inv_left > 0) ||
        bus4.game_over != (m4.started && m4.lives == 0) || bus4.life_lost != m4.ll) begin
      errors++;
      $display("FAIL rand_w4 cyc %0d: got lives=%0d inv=%0b go=%0b ll=%0b, want lives=%0d inv=%0b go=%0b ll=%0b",
               cyc, bus4.lives, bus4.invulnerable, bus4.game_over, bus4.life_lost,
               m4.lives, m4.inv_left > 0, m4.started && m4.lives == 0, m4.ll);
    end
    checks++;
    if (int'(bus1.lives) != m1.lives || bus1.invulnerable != (m1.inv_left > 0) ||
        bus1.game_over != (m1.started && m1.lives == 0) || bus1.life_lost != m1.ll) begin
      errors++;
      $display("FAIL rand_w1 cyc %0d: got lives=%0d inv=%0b go=%0b ll=%0b, want lives=%0d inv=%0b go=%0b ll=%0b",
               cyc, bus1.lives, bus1.invulnerable, bus1.game_over, bus1.life_lost,
               m1.lives, m1.inv_left > 0, m1.started && m1.lives == 0, m1.ll);
    end
  endtask

  // ---------------- vector table -----------------------------------------------
  typedef struct {
    bit s, h, e;
    int lives;
    bit inv, go, ll;
  } vec_t;

  vec_t vt[$];

  function automatic void add(input bit s, input bit h, input bit e,
                              input int l, input bit inv, input bit go, input bit ll);
    vec_t v;
    v.s = s; v.h = h; v.e = e; v.lives = l; v.inv = inv; v.go = go; v.ll = ll;
    vt.push_back(v);
  endfunction

  initial begin
    reset = 1'b1;
    bus4.start = 1'b0; bus4.hit = 1'b0; bus4.extra_life = 1'b0;
    m4 = mreset(); m1 = mreset();

    //   s h e   lives inv go ll
    add(0,0,0,  3, 0,0,0);   // IDLE idle
    add(0,1,0,  3, 0,0,0);   // IDLE ignores hit
    add(0,0,1,  3, 0,0,0);   // IDLE ignores bonus
    add(1,0,0,  3, 0,0,0);   // start -> PLAY
    add(0,0,0,  3, 0,0,0);
    add(0,1,0,  2, 1,0,1);   // hit: window cycle 1
    add(0,0,0,  2, 1,0,0);   // cycle 2
    add(0,1,0,  2, 1,0,0);   // cycle 3: hit ignored
    add(0,0,0,  2, 1,0,0);   // cycle 4
    add(0,0,0,  2, 0,0,0);   // window over
    add(0,1,0,  1, 1,0,1);
    add(0,0,0,  1, 1,0,0);
    add(0,0,0,  1, 1,0,0);
    add(0,0,0,  1, 1,0,0);
    add(0,0,0,  1, 0,0,0);
    add(0,1,1,  1, 1,0,1);   // hit+bonus at 1 life: no game over
    add(0,0,0,  1, 1,0,0);
    add(0,0,0,  1, 1,0,0);
    add(0,0,0,  1, 1,0,0);
    add(0,0,0,  1, 0,0,0);
    add(0,1,0,  0, 0,1,1);   // last life
    add(0,1,0,  0, 0,1,0);   // OVER holds
    add(0,0,1,  0, 0,1,0);
    add(1,0,0,  3, 0,0,0);   // restart
    add(0,0,1,  4, 0,0,0);
    add(0,0,1,  5, 0,0,0);
    add(0,0,1,  6, 0,0,0);
    add(0,0,1,  7, 0,0,0);
    add(0,0,1,  7, 0,0,0);   // saturates
    add(0,0,1,  7, 0,0,0);
    add(1,1,1,  3, 0,0,0);   // start beats hit and bonus
    add(0,1,0,  2, 1,0,1);
    add(0,0,1,  3, 1,0,0);   // bonus counts during window
    add(0,0,0,  3, 1,0,0);
    add(0,0,0,  3, 1,0,0);
    add(0,0,0,  3, 0,0,0);

    #12;
    check4("reset_state", 3, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vt.size(); i++) begin
      step(vt[i].s, vt[i].h, vt[i].e);
      check4($sformatf("vec%0d", i), vt[i].lives, vt[i].inv, vt[i].go, vt[i].ll);
    end

    // Async reset between edges, mid-window.
    step(0, 1, 0);
    check4("pre_reset_hit", 2, 1, 0, 1);
    bus4.hit = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check4("async_reset", 3, 0, 0, 0);
    m4 = mreset(); m1 = mreset();
    @(negedge clk);
    reset = 1'b0;
    step(0, 1, 0);
    check4("hit_after_reset_ignored", 3, 0, 0, 0);
    step(0, 0, 0);
    check4("idle_after_reset", 3, 0, 0, 0);

    // Random pulses against the model, both window lengths.
    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0);
      check_model(c);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
